// File: rtl/psrm_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron.
// PSRM_REFRACTORY_EN adds the REFRAC state to the FSM encoding.
package psrm_pkg;

    localparam int VW_DEF = 16;
    localparam int WW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEAK,
        CMP,
        FIRE
`ifdef PSRM_REFRACTORY_EN
        , REFRAC
`endif
    } state_t;

    // Add two sign-extended operands and clamp the sum to a signed w-bit range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] s, hi, lo;
        s  = 33'(a) + 33'(b);
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        if (s > hi)      return 32'(hi);
        else if (s < lo) return 32'(lo);
        else             return 32'(s);
    endfunction

endpackage

// File: rtl/psrm_leak_neuron_if.sv
// Event, control and status bundle of the leaky neuron.
interface psrm_leak_neuron_if #(
    parameter int VW = 16,
    parameter int WW = 8
);
    logic                 tick_i;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [WW-1:0] in_weight;
    logic        [7:0]    tau_i;
    logic signed [VW-1:0] vth_i;
    logic                 spike_o;
    logic signed [VW-1:0] vmem_o;
    logic                 tick_ovf_o;

    modport master (
        output tick_i, in_valid, in_weight, tau_i, vth_i,
        input  in_ready, spike_o, vmem_o, tick_ovf_o
    );

    modport slave (
        input  tick_i, in_valid, in_weight, tau_i, vth_i,
        output in_ready, spike_o, vmem_o, tick_ovf_o
    );
endinterface

// File: rtl/psrm_leak_neuron_find_pow2_8.sv
// Leak exponent helper: returns the MSB index of (val-1), i.e. ceil(log2(val))
// minus one, so the shift 1/2^(pow+1) approximates 1/tau.
module find_pow2_8 (
    input  logic [7:0] val,
    output logic [2:0] pow
);
    logic [7:0] m;

    always_comb begin
        m   = val - 8'd1;
        pow = '0;
        for (int i = 0; i < 8; i++)
            if (m[i]) pow = 3'(i);
    end
endmodule

// File: rtl/psrm_leak_neuron.sv
// Leaky integrate-and-fire neuron: saturating event accumulation, per-tick shift leak,
// threshold fire. Define PSRM_REFRACTORY_EN to enable the REFRAC dead time after a spike.
module psrm_leak_neuron
    import psrm_pkg::*;
#(
    parameter int VW      = VW_DEF,
    parameter int WW      = WW_DEF,
    parameter int REF_CYC = 4
) (
    input logic               clk,
    input logic               rst,
    psrm_leak_neuron_if.slave bus
);
    state_t               state;
    logic signed [VW-1:0] vmem;
    logic        [7:0]    tau_reg;
    logic                 tick_pend;
    logic                 tick_ovf;
    logic                 spike;
    logic        [2:0]    pw;
    logic        [3:0]    sh;
`ifdef PSRM_REFRACTORY_EN
    logic        [3:0]    ref_cnt;
`endif

    if (REF_CYC < 1 || REF_CYC > 15) begin : g_bad_ref
        $error("REF_CYC must be in 1..15");
    end

    find_pow2_8 u_fp2 (.val(tau_reg), .pow(pw));
    assign sh = {1'b0, pw} + 4'd1;

    assign bus.in_ready   = (state == IDLE);
    assign bus.spike_o    = spike;
    assign bus.vmem_o     = vmem;
    assign bus.tick_ovf_o = tick_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vmem      <= '0;
            tau_reg   <= '0;
            tick_pend <= 1'b0;
            tick_ovf  <= 1'b0;
            spike     <= 1'b0;
`ifdef PSRM_REFRACTORY_EN
            ref_cnt   <= '0;
`endif
        end else begin
            spike <= 1'b0;
            // IDLE services the pending tick first; a fresh tick arriving with it stays queued
            if (state == IDLE)
                tick_pend <= tick_pend & bus.tick_i;
            else if (bus.tick_i) begin
                if (tick_pend) tick_ovf  <= 1'b1;
                else           tick_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.in_valid)
                        vmem <= VW'(sat_add(32'(vmem), 32'(bus.in_weight), VW));
                    if (bus.tick_i || tick_pend) begin
                        tau_reg <= bus.tau_i;
                        state   <= LEAK;
                    end
                end
                LEAK: begin
                    if (tau_reg != 8'd0) vmem <= vmem - (vmem >>> sh);
                    state <= CMP;
                end
                CMP: begin
                    if (vmem >= bus.vth_i) begin
                        spike <= 1'b1;
                        state <= FIRE;
                    end else
                        state <= IDLE;
                end
                FIRE: begin
                    vmem <= '0;
`ifdef PSRM_REFRACTORY_EN
                    ref_cnt <= 4'(REF_CYC - 1);
                    state   <= REFRAC;
`else
                    state   <= IDLE;
`endif
                end
`ifdef PSRM_REFRACTORY_EN
                REFRAC: begin
                    if (ref_cnt == 4'd0) state <= IDLE;
                    else                 ref_cnt <= ref_cnt - 4'd1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psrm_leak_neuron.sv
// Scoreboard bench for psrm_leak_neuron; refractory expectations follow PSRM_REFRACTORY_EN.
module tb_psrm_leak_neuron;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    psrm_leak_neuron_if #(.VW(16), .WW(8)) bus ();
    psrm_leak_neuron #(.VW(16), .WW(8), .REF_CYC(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { string tag; int val; } exp_t;
    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    int mdl   = 0;

`ifdef PSRM_REFRACTORY_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input int got);
        exp_t e;
        if (sb.size() == 0) chk("sb_empty", got, -99999);
        else begin
            e = sb.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.tick_i = 1'b0;
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        mdl = 0;
    endtask

    // one accepted event; the model update is pushed, then compared against vmem_o
    task automatic send(input int w, input bit check);
        bus.in_weight = 8'(w);
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        mdl = clamp16(mdl + w);
        if (check) begin
            push("acc", mdl);
            pop_chk(int'(bus.vmem_o));
        end
    endtask

    initial begin
        bus.tick_i = 1'b0; bus.in_valid = 1'b0; bus.in_weight = '0;
        bus.tau_i = 8'd0; bus.vth_i = 16'sd32767;
        do_reset();
        chk("rst_vmem", int'(bus.vmem_o), 0);
        chk("rst_spike", int'(bus.spike_o), 0);
        chk("rst_ovf", int'(bus.tick_ovf_o), 0);
        chk("rst_ready", int'(bus.in_ready), 1);

        // plain accumulation
        send(100, 1); send(50, 1); send(-30, 1);
        chk("acc_spike", int'(bus.spike_o), 0);

        // leak: 1600 with tau=16 -> sh=4 -> 1500
        do_reset();
        for (int i = 0; i < 12; i++) send(127, 0);
        send(76, 1);
        bus.tau_i = 8'd16; bus.tick_i = 1'b1;
        step();
        bus.tick_i = 1'b0;
        chk("leak_busy", int'(bus.in_ready), 0);
        push("leak16", 1500);
        step();
        pop_chk(int'(bus.vmem_o));
        step();
        chk("leak_idle", int'(bus.in_ready), 1);
        // tau=3 -> sh=2: 1500-375; tau=1 -> sh=1: 1125-562
        bus.tau_i = 8'd3; bus.tick_i = 1'b1; step(); bus.tick_i = 1'b0;
        push("leak3", 1125); step(); pop_chk(int'(bus.vmem_o)); step();
        bus.tau_i = 8'd1; bus.tick_i = 1'b1; step(); bus.tick_i = 1'b0;
        push("leak1", 563); step(); pop_chk(int'(bus.vmem_o)); step();

        // saturation at both rails
        do_reset();
        for (int i = 0; i < 257; i++) send(127, 0);
        send(61, 1);
        send(127, 1);
        chk("sat_hi", int'(bus.vmem_o), 32767);
        do_reset();
        for (int i = 0; i < 255; i++) send(-128, 0);
        send(-120, 1);
        send(-128, 1);
        chk("sat_lo", int'(bus.vmem_o), -32768);
        send(-5, 1);

        // fire with tau=0 (no leak), spike in 3rd cycle after tick
        do_reset();
        bus.vth_i = 16'sd200; bus.tau_i = 8'd0;
        send(127, 0); send(127, 0); send(46, 1);
        bus.tick_i = 1'b1; step(); bus.tick_i = 1'b0;
        chk("fire_c1_spike", int'(bus.spike_o), 0);
        step();
        chk("fire_c2_spike", int'(bus.spike_o), 0);
        chk("fire_c2_vmem", int'(bus.vmem_o), 300);
        step();
        chk("fire_c3_spike", int'(bus.spike_o), 1);
        chk("fire_c3_ready", int'(bus.in_ready), 0);
        step();
        chk("fire_c4_spike", int'(bus.spike_o), 0);
        chk("fire_c4_vmem", int'(bus.vmem_o), 0);
        chk("fire_c4_ready", int'(bus.in_ready), REF_EN ? 0 : 1);
        if (REF_EN) begin
            bus.in_weight = 8'd50; bus.in_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                chk("refrac_ready", int'(bus.in_ready), 0);
            end
            bus.in_valid = 1'b0;
            step();
            chk("refrac_exit", int'(bus.in_ready), 1);
            chk("refrac_drop", int'(bus.vmem_o), 0);
        end

        // pending tick and overflow: three back-to-back ticks from 1024, tau=16
        do_reset();
        bus.vth_i = 16'sd32767; bus.tau_i = 8'd16;
        for (int i = 0; i < 8; i++) send(127, 0);
        send(8, 1);
        bus.tick_i = 1'b1;
        step();
        step();
        chk("pend_leak1", int'(bus.vmem_o), 960);
        step();
        bus.tick_i = 1'b0;
        chk("ovf_set", int'(bus.tick_ovf_o), 1);
        step();
        chk("pend_leak2_busy", int'(bus.in_ready), 0);
        push("pend_leak2", 900);
        step();
        pop_chk(int'(bus.vmem_o));
        for (int i = 0; i < 4; i++) step();
        chk("ovf_sticky", int'(bus.tick_ovf_o), 1);
        chk("pend_drained", int'(bus.vmem_o), 900);
        do_reset();
        chk("ovf_clr", int'(bus.tick_ovf_o), 0);

        // reset while in CMP with vmem over threshold
        bus.vth_i = 16'sd200; bus.tau_i = 8'd0;
        send(127, 0); send(127, 0); send(46, 0);
        bus.tick_i = 1'b1; step(); bus.tick_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstcmp_spike", int'(bus.spike_o), 0);
        chk("rstcmp_vmem", int'(bus.vmem_o), 0);
        step();
        chk("rstcmp_nospike", int'(bus.spike_o), 0);
        mdl = 0;

        // accept and tick in the same cycle: leak acts on the new value (tau=2 -> sh=1)
        bus.vth_i = 16'sd32767; bus.tau_i = 8'd2;
        bus.in_weight = 8'd100; bus.in_valid = 1'b1; bus.tick_i = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.tick_i = 1'b0;
        chk("coinc_acc", int'(bus.vmem_o), 100);
        push("coinc_leak", 50);
        step();
        pop_chk(int'(bus.vmem_o));
        step();

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/psrm_leak_neuron.md
PSRM_LEAK_NEURON -- requirements
Module: psrm_leak_neuron

Interface
REQ-001 SHALL have parameter VW, default 16, giving the signed membrane-potential width.
REQ-002 SHALL have parameter WW, default 8, giving the signed synaptic-weight width.
REQ-003 SHALL have parameter REF_CYC, default 4, giving the refractory length in cycles (1..15).
REQ-004 SHALL have port clk, input, 1 bit: the only clock, with all state updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port tick_i, input, 1 bit: one-cycle time-step strobe.
REQ-007 SHALL have port in_valid, input, 1 bit: weighted spike event present.
REQ-008 SHALL have port in_ready, output, 1 bit: event accepted when in_valid && in_ready.
REQ-009 SHALL have port in_weight, input, WW bits: signed synaptic weight.
REQ-010 SHALL have port tau_i, input, 8 bits: leak time constant; 0 disables leak.
REQ-011 SHALL have port vth_i, input, VW bits: signed firing threshold.
REQ-012 SHALL have port spike_o, output, 1 bit: one-cycle output spike.
REQ-013 SHALL have port vmem_o, output, VW bits: registered membrane potential.
REQ-014 SHALL have port tick_ovf_o, output, 1 bit: sticky flag set when a tick is lost.

Function
REQ-015 SHALL use FSM states IDLE, LEAK, CMP, FIRE and REFRAC.
REQ-016 SHALL drive in_ready=1 only in IDLE.
REQ-017 SHALL, on accept, set vmem <= sat(vmem + sext(in_weight)), saturating to the signed VW range.
REQ-018 SHALL, in IDLE with tick_i or tick_pend, register tau_i, go to LEAK next cycle and clear tick_pend.
REQ-019 SHALL, when accept and tick coincide in IDLE, accumulate first so LEAK acts on the new vmem.
REQ-020 SHALL compute sh = find_pow2(tau_reg) + 1 (range 1..8).
REQ-021 SHALL in LEAK set vmem <= vmem - (vmem >>> sh) when tau_reg != 0, hold vmem when tau_reg == 0, then go to CMP.
REQ-022 SHALL in CMP go to FIRE if vmem >= vth_i (signed compare), else to IDLE.
REQ-023 SHALL in FIRE pulse spike_o for exactly one cycle, set vmem <= 0, and go to REFRAC.
REQ-024 SHALL hold REFRAC for REF_CYC cycles, drop events (in_ready=0), then return to IDLE.
REQ-025 SHALL, on tick_i outside IDLE, set tick_pend.
REQ-026 SHALL, on tick_i with tick_pend already set, drop the tick and set tick_ovf_o.
REQ-027 SHALL take leak latency of 2 cycles from tick to CMP decision, with spike_o in the 3rd cycle after the tick.
REQ-028 SHALL drive vmem_o directly from the vmem register.

Reset
REQ-029 SHALL on rst set state=IDLE, vmem=0, spike_o=0, tick_pend=0, tick_ovf_o=0, tau_reg=0 and refractory counter=0.
REQ-030 SHALL let rst mid-operation (any state) override all transitions in that cycle with no spike emitted.
REQ-031 SHALL clear tick_ovf_o only by rst.

Configuration
REQ-032 SHALL, with macro PSRM_REFRACTORY_EN defined, behave as in REQ-024.
REQ-033 SHALL, without PSRM_REFRACTORY_EN, go from FIRE straight to IDLE, remove the REFRAC state and counter, and ignore REF_CYC.

Structure
REQ-034 SHALL import package psrm_pkg holding the FSM state enum, the sat_add function and default VW/WW constants.
REQ-035 SHALL instantiate find_pow2_8 once to convert tau_reg to the leak exponent, with no other sub-modules.

Verification
REQ-036 SHALL cover: accept weights 100,50,-30 with no tick -> vmem_o=120, spike_o=0.
REQ-037 SHALL cover: vmem=1600, tau_i=16 (sh=4), tick -> vmem_o=1500 after 2 cycles.
REQ-038 SHALL cover: vmem=32700, weight +127 -> vmem_o=32767 (saturation); vmem=-32760, weight -128 -> vmem_o=-32768.
REQ-039 SHALL cover: vth=200, vmem=300, tau_i=0, tick -> spike_o high 1 cycle in 3rd cycle after tick, vmem_o=0, in_ready=0 for REF_CYC=4 cycles, with an event in REFRAC dropped.
REQ-040 SHALL cover: tick during LEAK -> second leak follows immediately on return to IDLE; third tick before service -> tick_ovf_o=1 until rst.
REQ-041 SHALL cover: rst asserted in CMP with vmem >= vth -> no spike, vmem_o=0 next cycle; rerun REQ-039 without PSRM_REFRACTORY_EN -> in_ready=1 the cycle after FIRE.
